// File: rtl/pcq_pkg.sv
// Shared constants, class encoding and entry layout for the two-class customer queue.
package pcq_pkg;

  localparam int unsigned PCQ_DT_SZ   = 4;
  localparam int unsigned PCQ_DEPTH   = 4;
  localparam int unsigned PCQ_AGE_LIM = 3;

  typedef enum logic {
    CLS_NRM = 1'b0,
    CLS_VIP = 1'b1
  } pcq_cls_e;

  // Ring storage packs entries as {num, tm}; this struct documents that layout at default width.
  typedef struct packed {
    logic [PCQ_DT_SZ-1:0] num;
    logic [PCQ_DT_SZ-1:0] tm;
  } pcq_entry_t;

endpackage

// File: rtl/pcq_ring.sv
// Single-class circular buffer: storage, head/tail/count, full/empty flags and head data.
module pcq_ring #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] cnt
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr, rd;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign cnt   = cnt_q;
  assign dout  = mem_q[head_q];

  // Fullness is judged before any same-cycle pop, so a full ring rejects writes even while draining.
  assign wr = push && !full;
  assign rd = pop && !empty;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (wr) tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
    if (rd) head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
    if (wr && !rd) cnt_d = cnt_q + 1'b1;
    else if (rd && !wr) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (wr) mem_q[tail_q] <= din;
    end
  end

endmodule

// File: rtl/prio_cust_queue.sv
// VIP/normal customer queue with aging arbitration and drop reporting.
// Optional statistics outputs are enabled by defining PCQ_STATS_EN.
module prio_cust_queue
  import pcq_pkg::*;
#(
  parameter int unsigned DT_SZ   = PCQ_DT_SZ,
  parameter int unsigned DEPTH   = PCQ_DEPTH,
  parameter int unsigned CW      = $clog2(DEPTH + 1),
  parameter int unsigned AGE_LIM = PCQ_AGE_LIM
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             wvip,
  input  logic [DT_SZ-1:0] dn,
  input  logic [DT_SZ-1:0] dt,
  input  logic             re,
  output logic             valid,
  output logic [DT_SZ-1:0] qn,
  output logic [DT_SZ-1:0] qt,
  output logic             qvip,
  output logic             full_v,
  output logic             full_n,
  output logic [CW-1:0]    cnt_v,
  output logic [CW-1:0]    cnt_n,
`ifdef PCQ_STATS_EN
  output logic [7:0]       st_enq,
  output logic [7:0]       st_drop,
  output logic [CW-1:0]    st_max,
`endif
  output logic             drop
);

  localparam int unsigned AW = $clog2(AGE_LIM + 1);

  logic [2*DT_SZ-1:0] din, head_v, head_n;
  logic               empty_v, empty_n;
  logic               push_v, push_n, pop_v, pop_n;
  logic               tgt_full;
  pcq_cls_e           sel;
  logic [AW-1:0]      age_q, age_d;
  logic               drop_q;

  assign din    = {dn, dt};
  assign push_v = we && wvip;
  assign push_n = we && !wvip;

  pcq_ring #(.W(2 * DT_SZ), .DEPTH(DEPTH), .CW(CW)) u_ring_v (
    .clk(clk), .rst(rst), .push(push_v), .pop(pop_v), .din(din),
    .dout(head_v), .full(full_v), .empty(empty_v), .cnt(cnt_v)
  );

  pcq_ring #(.W(2 * DT_SZ), .DEPTH(DEPTH), .CW(CW)) u_ring_n (
    .clk(clk), .rst(rst), .push(push_n), .pop(pop_n), .din(din),
    .dout(head_n), .full(full_n), .empty(empty_n), .cnt(cnt_n)
  );

  always_comb begin
    sel = CLS_NRM;
    if (!empty_v && (empty_n || age_q < AW'(AGE_LIM))) sel = CLS_VIP;
  end

  assign valid    = !empty_v || !empty_n;
  assign pop_v    = re && valid && (sel == CLS_VIP);
  assign pop_n    = re && valid && (sel == CLS_NRM);
  assign qvip     = valid && (sel == CLS_VIP);
  assign {qn, qt} = !valid ? '0 : (sel == CLS_VIP) ? head_v : head_n;
  assign tgt_full = wvip ? full_v : full_n;
  assign drop     = drop_q;

  // Age only counts VIP pops that overtook a waiting normal entry.
  always_comb begin
    age_d = age_q;
    if (empty_n || pop_n) age_d = '0;
    else if (pop_v && age_q != AW'(AGE_LIM)) age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      age_q  <= age_d;
      drop_q <= we && tgt_full;
    end
  end

`ifdef PCQ_STATS_EN
  localparam int unsigned CAP = (2 * DEPTH < (2 ** CW) - 1) ? 2 * DEPTH : (2 ** CW) - 1;

  logic [7:0]    st_enq_q, st_drop_q;
  logic [CW-1:0] st_max_q;
  logic [CW:0]   total;

  assign total   = {1'b0, cnt_v} + {1'b0, cnt_n};
  assign st_enq  = st_enq_q;
  assign st_drop = st_drop_q;
  assign st_max  = st_max_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      st_enq_q  <= '0;
      st_drop_q <= '0;
      st_max_q  <= '0;
    end else begin
      if (we && !tgt_full && st_enq_q != '1) st_enq_q <= st_enq_q + 1'b1;
      if (we && tgt_full && st_drop_q != '1) st_drop_q <= st_drop_q + 1'b1;
      if (total > {1'b0, st_max_q})
        st_max_q <= (total > (CW + 1)'(CAP)) ? CW'(CAP) : total[CW-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_prio_cust_queue.sv
// Directed self-checking bench for prio_cust_queue (DEPTH=4, AGE_LIM=3, 8-bit fields).
module tb_prio_cust_queue;

  localparam int unsigned DT    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 3;

  logic          clk = 1'b0;
  logic          rst, we, wvip, re;
  logic [DT-1:0] dn, dt, qn, qt;
  logic          valid, qvip, full_v, full_n, drop;
  logic [CW-1:0] cnt_v, cnt_n;
`ifdef PCQ_STATS_EN
  logic [7:0]    st_enq, st_drop;
  logic [CW-1:0] st_max;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  prio_cust_queue #(.DT_SZ(DT), .DEPTH(DEPTH), .CW(CW), .AGE_LIM(3)) dut (
    .clk(clk), .rst(rst), .we(we), .wvip(wvip), .dn(dn), .dt(dt), .re(re),
    .valid(valid), .qn(qn), .qt(qt), .qvip(qvip), .full_v(full_v), .full_n(full_n),
    .cnt_v(cnt_v), .cnt_n(cnt_n),
`ifdef PCQ_STATS_EN
    .st_enq(st_enq), .st_drop(st_drop), .st_max(st_max),
`endif
    .drop(drop)
  );

  task automatic drive(input logic w, input logic v, input logic r,
                       input logic [DT-1:0] n, input logic [DT-1:0] t);
    we = w; wvip = v; re = r; dn = n; dt = t;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b1, i[0], 1'b0, 8'd5, 8'd5);
    rst = 1'b0;
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b exp 0", valid); end
    tests_run++; if (cnt_v !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt_v: got %0d exp 0", cnt_v); end
    tests_run++; if (cnt_n !== 3'd0) begin tests_failed++; $display("FAIL reset_cnt_n: got %0d exp 0", cnt_n); end
    tests_run++; if (qn !== 8'd0 || qt !== 8'd0) begin tests_failed++; $display("FAIL reset_head: got qn=%0d qt=%0d exp 0/0", qn, qt); end
    tests_run++; if (drop !== 1'b0) begin tests_failed++; $display("FAIL reset_drop: got %b exp 0", drop); end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tests_run++; if (drop !== 1'b0 || valid !== 1'b0) begin tests_failed++; $display("FAIL reset_post: got drop=%b valid=%b exp 0/0", drop, valid); end
  endtask

  task automatic test_class_order();
    logic [DT-1:0] en [3];
    logic [DT-1:0] et [3];
    logic          ev [3];
    en = '{8'd2, 8'd1, 8'd3};
    et = '{8'd3, 8'd5, 8'd7};
    ev = '{1'b1, 1'b0, 1'b0};
    drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd5);
    drive(1'b1, 1'b1, 1'b0, 8'd2, 8'd3);
    drive(1'b1, 1'b0, 1'b0, 8'd3, 8'd7);
    tests_run++; if (cnt_v !== 3'd1 || cnt_n !== 3'd2) begin tests_failed++; $display("FAIL order_cnt: got v=%0d n=%0d exp 1/2", cnt_v, cnt_n); end
    for (int i = 0; i < 3; i++) begin
      tests_run++; if (qn !== en[i] || qt !== et[i]) begin tests_failed++; $display("FAIL order_head[%0d]: got %0d/%0d exp %0d/%0d", i, qn, qt, en[i], et[i]); end
      tests_run++; if (qvip !== ev[i]) begin tests_failed++; $display("FAIL order_qvip[%0d]: got %b exp %b", i, qvip, ev[i]); end
      drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    end
    tests_run++; if (valid !== 1'b0 || qn !== 8'd0) begin tests_failed++; $display("FAIL order_empty: got valid=%b qn=%0d exp 0/0", valid, qn); end
  endtask

  task automatic test_aging();
    logic [DT-1:0] en [6];
    logic          ev [6];
    en = '{8'd10, 8'd11, 8'd12, 8'd20, 8'd13, 8'd14};
    ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, DT'(10 + i), DT'(i));
    drive(1'b1, 1'b0, 1'b0, 8'd20, 8'd9);
    tests_run++; if (full_v !== 1'b1 || cnt_v !== 3'd4 || cnt_n !== 3'd1) begin tests_failed++; $display("FAIL aging_fill: got full_v=%b v=%0d n=%0d exp 1/4/1", full_v, cnt_v, cnt_n); end
    for (int i = 0; i < 6; i++) begin
      tests_run++; if (qn !== en[i] || qvip !== ev[i]) begin tests_failed++; $display("FAIL aging_pop[%0d]: got qn=%0d qvip=%b exp %0d/%b", i, qn, qvip, en[i], ev[i]); end
      if (i == 1) drive(1'b1, 1'b1, 1'b1, 8'd14, 8'd4);
      else        drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL aging_empty: got valid=%b exp 0", valid); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, DT'(i + 1), DT'(i + 1));
    tests_run++; if (full_v !== 1'b1 || drop !== 1'b0) begin tests_failed++; $display("FAIL ovf_full: got full_v=%b drop=%b exp 1/0", full_v, drop); end
    drive(1'b1, 1'b1, 1'b0, 8'd9, 8'd9);
    tests_run++; if (drop !== 1'b1 || cnt_v !== 3'd4) begin tests_failed++; $display("FAIL ovf_drop: got drop=%b cnt_v=%0d exp 1/4", drop, cnt_v); end
    drive(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    tests_run++; if (drop !== 1'b0 || cnt_v !== 3'd4) begin tests_failed++; $display("FAIL ovf_pulse: got drop=%b cnt_v=%0d exp 0/4", drop, cnt_v); end
    for (int i = 0; i < 4; i++) begin
      tests_run++; if (qn !== DT'(i + 1)) begin tests_failed++; $display("FAIL ovf_pop[%0d]: got %0d exp %0d", i, qn, i + 1); end
      drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    end
    tests_run++; if (valid !== 1'b0 || cnt_v !== 3'd0) begin tests_failed++; $display("FAIL ovf_empty: got valid=%b cnt_v=%0d exp 0/0", valid, cnt_v); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b0, 8'd1, 8'd1);
    drive(1'b1, 1'b0, 1'b0, 8'd2, 8'd2);
    for (int k = 0; k < 10; k++) begin
      tests_run++; if (qn !== DT'(k + 1)) begin tests_failed++; $display("FAIL wrap_head[%0d]: got %0d exp %0d", k, qn, k + 1); end
      drive(1'b1, 1'b0, 1'b1, DT'(k + 3), DT'(k + 3));
      tests_run++; if (cnt_n !== 3'd2) begin tests_failed++; $display("FAIL wrap_cnt[%0d]: got %0d exp 2", k, cnt_n); end
    end
    for (int k = 11; k <= 12; k++) begin
      tests_run++; if (qn !== DT'(k) || qt !== DT'(k)) begin tests_failed++; $display("FAIL wrap_drain: got %0d/%0d exp %0d", qn, qt, k); end
      drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    end
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("FAIL wrap_empty: got valid=%b exp 0", valid); end
  endtask

  task automatic test_empty_corner();
    drive(1'b1, 1'b0, 1'b1, 8'd6, 8'd2);
    tests_run++; if (valid !== 1'b1 || qn !== 8'd6 || qt !== 8'd2 || cnt_n !== 3'd1) begin tests_failed++; $display("FAIL corner_wr_rd: got valid=%b qn=%0d qt=%0d cnt_n=%0d exp 1/6/2/1", valid, qn, qt, cnt_n); end
    for (int i = 7; i <= 9; i++) drive(1'b1, 1'b0, 1'b0, DT'(i), DT'(i));
    tests_run++; if (full_n !== 1'b1 || cnt_n !== 3'd4) begin tests_failed++; $display("FAIL corner_full: got full_n=%b cnt_n=%0d exp 1/4", full_n, cnt_n); end
    drive(1'b1, 1'b0, 1'b1, 8'd15, 8'd15);
    tests_run++; if (drop !== 1'b1 || cnt_n !== 3'd3 || qn !== 8'd7) begin tests_failed++; $display("FAIL corner_full_pp: got drop=%b cnt_n=%0d qn=%0d exp 1/3/7", drop, cnt_n, qn); end
    for (int i = 7; i <= 9; i++) begin
      tests_run++; if (qn !== DT'(i)) begin tests_failed++; $display("FAIL corner_drain: got %0d exp %0d", qn, i); end
      drive(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
    end
    tests_run++; if (valid !== 1'b0 || drop !== 1'b0) begin tests_failed++; $display("FAIL corner_empty: got valid=%b drop=%b exp 0/0", valid, drop); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wvip = 1'b0; re = 1'b0; dn = '0; dt = '0;
    test_reset();
    test_class_order();
    test_aging();
    test_overflow();
    test_wrap();
    test_empty_corner();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got no finish exp finish");
    $fatal(1);
  end

endmodule
